// File: rtl/vec_pkg.sv
// Shared vector decode types: opcode/func enums, the queued micro-op record,
// the vill bit position and the VLMAX/vl helper.
package vec_pkg;

    // Wide payload fields are stored at this width and sliced to XLEN at the top.
    localparam int UOP_XW = 64;

    typedef enum logic [6:0] {
        OP_LOADFP  = 7'h07,
        OP_STOREFP = 7'h27,
        OP_V       = 7'h57
    } opcode_e;

    typedef enum logic [2:0] {
        F3_OPIVV = 3'b000,
        F3_OPFVV = 3'b001,
        F3_OPMVV = 3'b010,
        F3_OPIVI = 3'b011,
        F3_OPIVX = 3'b100,
        F3_OPFVF = 3'b101,
        F3_OPMVX = 3'b110,
        F3_OPCFG = 3'b111
    } func3_e;

    typedef enum logic [5:0] {
        F6_VADD   = 6'b000000,
        F6_VSUB   = 6'b000010,
        F6_VRSUB  = 6'b000011,
        F6_VMINU  = 6'b000100,
        F6_VMIN   = 6'b000101,
        F6_VMAXU  = 6'b000110,
        F6_VMAX   = 6'b000111,
        F6_VAND   = 6'b001001,
        F6_VOR    = 6'b001010,
        F6_VXOR   = 6'b001011,
        F6_VMERGE = 6'b010111,
        F6_VMSEQ  = 6'b011000,
        F6_VMSNE  = 6'b011001,
        F6_VSLL   = 6'b100101,
        F6_VSRL   = 6'b101000,
        F6_VSRA   = 6'b101001
    } func6_int_e;

    typedef enum logic [5:0] {
        F6_VMULHU  = 6'b100100,
        F6_VMUL    = 6'b100101,
        F6_VMULHSU = 6'b100110,
        F6_VMULH   = 6'b100111,
        F6_VMADD   = 6'b101001,
        F6_VNMSUB  = 6'b101011,
        F6_VMACC   = 6'b101101,
        F6_VNMSAC  = 6'b101111
    } func6_mul_e;

    typedef enum logic [1:0] {
        UC_ARITH = 2'd0,
        UC_LOAD  = 2'd1,
        UC_STORE = 2'd2
    } uop_class_e;

    typedef struct packed {
        uop_class_e          cls;
        logic [2:0]          func3;
        logic [5:0]          func6;
        logic [4:0]          vd;
        logic [4:0]          vs1;
        logic [4:0]          vs2;
        logic                vm;
        logic [UOP_XW-1:0]   imm;
        logic [UOP_XW-1:0]   scalar;
        logic [UOP_XW-1:0]   stride;
        logic [2:0]          width;
        logic [2:0]          nf;
        logic [1:0]          mop;
        logic                illegal;
        logic [UOP_XW-1:0]   vl;
        logic [UOP_XW-1:0]   vtype;
    } uop_t;

    function automatic int vill_idx(input int xlen);
        return xlen - 1;
    endfunction

    function automatic logic func6_legal(input logic [2:0] func3, input logic [5:0] func6);
        logic int_op;
        logic mul_op;
        int_op = func6 inside {F6_VADD, F6_VSUB, F6_VRSUB, F6_VMINU, F6_VMIN, F6_VMAXU,
                               F6_VMAX, F6_VAND, F6_VOR, F6_VXOR, F6_VMERGE, F6_VMSEQ,
                               F6_VMSNE, F6_VSLL, F6_VSRL, F6_VSRA};
        mul_op = func6 inside {F6_VMULHU, F6_VMUL, F6_VMULHSU, F6_VMULH, F6_VMADD,
                               F6_VNMSUB, F6_VMACC, F6_VNMSAC};
        case (func3)
            F3_OPIVV: return int_op && (func6 != F6_VRSUB);
            F3_OPIVX: return int_op;
            F3_OPIVI: return int_op && (func6 != F6_VSUB)
                             && !(func6 inside {F6_VMINU, F6_VMIN, F6_VMAXU, F6_VMAX});
            F3_OPMVV, F3_OPMVX: return mul_op;
            default:  return 1'b0;
        endcase
    endfunction

    // vl = min(AVL, VLEN * LMUL / SEW) with SEW = 8 << vsew, LMUL = 1 << vlmul.
    function automatic logic [UOP_XW-1:0] calc_vl(input logic [UOP_XW-1:0] avl,
                                                  input logic [1:0] vsew,
                                                  input logic [1:0] vlmul,
                                                  input int vlen);
        logic [UOP_XW-1:0] vlmax;
        vlmax = (UOP_XW'(vlen) << vlmul) >> (3 + vsew);
        return (avl < vlmax) ? avl : vlmax;
    endfunction

endpackage

// File: rtl/vec_uop_fifo.sv
// Micro-op queue: power-of-two ring buffer with occupancy count; payload is not reset.
module vec_uop_fifo
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/vec_decode_pipe.sv
// Vector decode front-end: executes vset* configuration against the vl/vtype CSRs
// and queues decoded arithmetic/load/store micro-ops for the vector backend.
module vec_decode_pipe
    import vec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] vec_inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            uop_valid,
    input  logic            uop_ready,
    output logic [1:0]      uop_class,
    output logic [2:0]      uop_func3,
    output logic [5:0]      uop_func6,
    output logic [4:0]      uop_vd,
    output logic [4:0]      uop_vs1,
    output logic [4:0]      uop_vs2,
    output logic            uop_vm,
    output logic [XLEN-1:0] uop_imm,
    output logic [XLEN-1:0] uop_scalar,
    output logic [XLEN-1:0] uop_stride,
    output logic [2:0]      uop_width,
    output logic [2:0]      uop_nf,
    output logic [1:0]      uop_mop,
    output logic            uop_illegal,
    output logic [XLEN-1:0] uop_vl,
    output logic [XLEN-1:0] uop_vtype,
    output logic            rd_wb_valid,
    output logic [4:0]      rd_wb_addr,
    output logic [XLEN-1:0] rd_wb_data,
    output logic [XLEN-1:0] csr_vl,
    output logic [XLEN-1:0] csr_vtype
);

    localparam int              VILL       = vill_idx(XLEN);
    localparam logic [XLEN-1:0] VILL_VTYPE = XLEN'(1) << VILL;

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [5:0]      f6;
    logic            handshake, is_cfg, is_arith, is_load, is_store, cfg_hs;
    logic            fifo_full, fifo_empty;
    uop_t            uop_in, head;

    logic [XLEN-1:0] csr_vl_q, csr_vl_d, csr_vtype_q, csr_vtype_d;
    logic [XLEN-1:0] vtype_raw, avl;
    logic            is_ivli, keep_vl, cfg_vill;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            unused_mew;

    assign opcode     = vec_inst[6:0];
    assign rd         = vec_inst[11:7];
    assign f3         = vec_inst[14:12];
    assign rs1        = vec_inst[19:15];
    assign rs2        = vec_inst[24:20];
    assign f6         = vec_inst[31:26];
    assign unused_mew = vec_inst[28];

    assign handshake = inst_valid && inst_ready;
    assign is_cfg    = (opcode == OP_V) && (f3 == F3_OPCFG);
    assign is_arith  = (opcode == OP_V) && (f3 != F3_OPCFG);
    assign is_load   = (opcode == OP_LOADFP);
    assign is_store  = (opcode == OP_STOREFP);
    assign cfg_hs    = handshake && is_cfg;

    always_comb begin
        uop_in         = '0;
        uop_in.cls     = is_load ? UC_LOAD : (is_store ? UC_STORE : UC_ARITH);
        uop_in.func3   = f3;
        uop_in.func6   = f6;
        uop_in.vd      = rd;
        uop_in.vs1     = rs1;
        uop_in.vs2     = rs2;
        uop_in.vm      = vec_inst[25];
        uop_in.imm     = {{(UOP_XW-5){rs1[4]}}, rs1};
        uop_in.scalar  = UOP_XW'(rs1_data);
        uop_in.stride  = UOP_XW'(rs2_data);
        uop_in.width   = f3;
        uop_in.nf      = vec_inst[31:29];
        uop_in.mop     = vec_inst[27:26];
        uop_in.illegal = is_arith && (!func6_legal(f3, f6) || csr_vtype_q[VILL]);
        uop_in.vl      = UOP_XW'(csr_vl_q);
        uop_in.vtype   = UOP_XW'(csr_vtype_q);
    end

    vec_uop_fifo #(
        .DEPTH (DEPTH),
        .T     (uop_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (handshake && (is_arith || is_load || is_store)),
        .din_i   (uop_in),
        .pop_i   (uop_ready),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // vsetvli: bit31=0, zimm[10:0]; vsetivli: bits31:30=11, zimm[9:0], uimm AVL; vsetvl: rs2_data.
    always_comb begin
        is_ivli = vec_inst[31] && vec_inst[30];
        if (!vec_inst[31]) begin
            vtype_raw = XLEN'(vec_inst[30:20]);
        end else if (vec_inst[30]) begin
            vtype_raw = XLEN'(vec_inst[29:20]);
        end else begin
            vtype_raw = rs2_data;
        end
        if (is_ivli) begin
            avl = XLEN'(rs1);
        end else if (rs1 != 5'd0) begin
            avl = rs1_data;
        end else begin
            avl = '1;
        end
        keep_vl  = !is_ivli && (rs1 == 5'd0) && (rd == 5'd0);
        cfg_vill = (vtype_raw[5:3] > 3'd3) || vtype_raw[2] || (|vtype_raw[XLEN-1:8]);

        csr_vl_d    = csr_vl_q;
        csr_vtype_d = csr_vtype_q;
        if (cfg_hs) begin
            if (cfg_vill) begin
                csr_vl_d    = '0;
                csr_vtype_d = VILL_VTYPE;
            end else begin
                csr_vtype_d = vtype_raw;
                if (!keep_vl) begin
                    csr_vl_d = XLEN'(calc_vl(UOP_XW'(avl), vtype_raw[4:3], vtype_raw[1:0], VLEN));
                end
            end
        end

        wb_valid_d = cfg_hs;
        wb_addr_d  = cfg_hs ? rd : wb_addr_q;
        wb_data_d  = cfg_hs ? csr_vl_d : wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_vl_q    <= '0;
            csr_vtype_q <= VILL_VTYPE;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            csr_vl_q    <= csr_vl_d;
            csr_vtype_q <= csr_vtype_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign inst_ready  = !fifo_full;
    assign uop_valid   = !fifo_empty;
    assign uop_class   = head.cls;
    assign uop_func3   = head.func3;
    assign uop_func6   = head.func6;
    assign uop_vd      = head.vd;
    assign uop_vs1     = head.vs1;
    assign uop_vs2     = head.vs2;
    assign uop_vm      = head.vm;
    assign uop_imm     = head.imm[XLEN-1:0];
    assign uop_scalar  = head.scalar[XLEN-1:0];
    assign uop_stride  = head.stride[XLEN-1:0];
    assign uop_width   = head.width;
    assign uop_nf      = head.nf;
    assign uop_mop     = head.mop;
    assign uop_illegal = head.illegal;
    assign uop_vl      = head.vl[XLEN-1:0];
    assign uop_vtype   = head.vtype[XLEN-1:0];
    assign rd_wb_valid = wb_valid_q;
    assign rd_wb_addr  = wb_addr_q;
    assign rd_wb_data  = wb_data_q;
    assign csr_vl      = csr_vl_q;
    assign csr_vtype   = csr_vtype_q;

    if (XLEN < UOP_XW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{head.imm[UOP_XW-1:XLEN], head.scalar[UOP_XW-1:XLEN],
                             head.stride[UOP_XW-1:XLEN], head.vl[UOP_XW-1:XLEN],
                             head.vtype[UOP_XW-1:XLEN]};
    end

endmodule

// File: tb/tb_vec_decode_pipe.sv
// Scoreboard bench for vec_decode_pipe: config writeback/CSR checks, queue
// occupancy model, in-order dispatch and reset flush.
module tb_vec_decode_pipe;

    localparam int XLEN  = 32;
    localparam int VLEN  = 512;
    localparam int DEPTH = 4;
    localparam logic [31:0] VILL_VT = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            inst_valid = 1'b0;
    logic            inst_ready;
    logic [XLEN-1:0] vec_inst = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic            uop_valid;
    logic            uop_ready = 1'b0;
    logic [1:0]      uop_class;
    logic [2:0]      uop_func3;
    logic [5:0]      uop_func6;
    logic [4:0]      uop_vd, uop_vs1, uop_vs2;
    logic            uop_vm;
    logic [XLEN-1:0] uop_imm, uop_scalar, uop_stride;
    logic [2:0]      uop_width, uop_nf;
    logic [1:0]      uop_mop;
    logic            uop_illegal;
    logic [XLEN-1:0] uop_vl, uop_vtype;
    logic            rd_wb_valid;
    logic [4:0]      rd_wb_addr;
    logic [XLEN-1:0] rd_wb_data;
    logic [XLEN-1:0] csr_vl, csr_vtype;

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        illegal;
        logic [2:0]  width;
        logic [31:0] vl;
        logic [31:0] vtype;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          mcnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_vl = '0;
    logic [31:0] exp_vtype = VILL_VT;

    vec_decode_pipe #(.XLEN(XLEN), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .vec_inst(vec_inst),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_class(uop_class), .uop_func3(uop_func3), .uop_func6(uop_func6),
        .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vm(uop_vm),
        .uop_imm(uop_imm), .uop_scalar(uop_scalar), .uop_stride(uop_stride),
        .uop_width(uop_width), .uop_nf(uop_nf), .uop_mop(uop_mop),
        .uop_illegal(uop_illegal), .uop_vl(uop_vl), .uop_vtype(uop_vtype),
        .rd_wb_valid(rd_wb_valid), .rd_wb_addr(rd_wb_addr), .rd_wb_data(rd_wb_data),
        .csr_vl(csr_vl), .csr_vtype(csr_vtype)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                 input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_arith(input logic [5:0] f6, input logic [2:0] f3,
                                              input logic [4:0] vd, input logic [4:0] vs2,
                                              input logic [4:0] vs1);
        return {f6, 1'b1, vs2, vs1, f3, vd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vle32(input logic [4:0] vd, input logic [4:0] rs1);
        return {3'b000, 1'b0, 2'b00, 1'b1, 5'b00000, rs1, 3'b110, vd, 7'h07};
    endfunction

    function automatic bit is_enq(input logic [31:0] inst);
        return ((inst[6:0] == 7'h57) && (inst[14:12] != 3'b111))
               || (inst[6:0] == 7'h07) || (inst[6:0] == 7'h27);
    endfunction

    // Occupancy model and in-order dispatch checking.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inst_ready", inst_ready, mcnt != DEPTH);
            chk("uop_valid", uop_valid, mcnt != 0);
            if (uop_valid && uop_ready) begin
                chk("dispatch_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("uop_class", uop_class, mon_e.cls);
                    chk("uop_vd", uop_vd, mon_e.vd);
                    chk("uop_vs1", uop_vs1, mon_e.vs1);
                    chk("uop_vs2", uop_vs2, mon_e.vs2);
                    chk("uop_illegal", uop_illegal, mon_e.illegal);
                    chk("uop_width", uop_width, mon_e.width);
                    chk("uop_vl", uop_vl, mon_e.vl);
                    chk("uop_vtype", uop_vtype, mon_e.vtype);
                end
            end
            if (reset) begin
                mcnt = 0;
            end else begin
                mcnt = mcnt + int'(inst_valid && (mcnt != DEPTH) && is_enq(vec_inst))
                            - int'((mcnt != 0) && uop_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                         input logic ill);
        exp_t e;
        vec_inst   = inst;
        rs1_data   = r1;
        rs2_data   = r2;
        inst_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (inst_ready) break;
            step();
        end
        chk("issue_accept", inst_ready, 1);
        if (inst_ready && is_enq(inst)) begin
            e.cls     = (inst[6:0] == 7'h07) ? 2'd1 : ((inst[6:0] == 7'h27) ? 2'd2 : 2'd0);
            e.vd      = inst[11:7];
            e.vs1     = inst[19:15];
            e.vs2     = inst[24:20];
            e.illegal = ill;
            e.width   = inst[14:12];
            e.vl      = exp_vl;
            e.vtype   = exp_vtype;
            sb.push_back(e);
        end
        step();
        inst_valid = 1'b0;
    endtask

    task automatic cfg(input string tag, input logic [31:0] inst, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] ea, input logic [31:0] evl,
                       input logic [31:0] evt);
        issue(inst, r1, r2, 1'b0);
        chk({tag, "_wb_valid"}, rd_wb_valid, 1);
        chk({tag, "_wb_addr"}, rd_wb_addr, ea);
        chk({tag, "_wb_data"}, rd_wb_data, evl);
        chk({tag, "_csr_vl"}, csr_vl, evl);
        chk({tag, "_csr_vtype"}, csr_vtype, evt);
        exp_vl    = evl;
        exp_vtype = evt;
        step();
        chk({tag, "_wb_pulse"}, rd_wb_valid, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("drain", sb.size(), 0);
        step();
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_wb_valid", rd_wb_valid, 0);
        chk("rst_csr_vl", csr_vl, 0);
        chk("rst_csr_vtype", csr_vtype, VILL_VT);
        mon_en = 1'b1;

        uop_ready = 1'b1;
        cfg("vsetvli", enc_vsetvli(5'd5, 5'd6, 11'h010), 32'd100, 32'd0, 5'd5, 32'd16, 32'h10);
        cfg("vsetivli", enc_vsetivli(5'd1, 5'd3, 10'h003), 32'd0, 32'd0, 5'd1, 32'd3, 32'h03);
        cfg("keepvl", enc_vsetvli(5'd0, 5'd0, 11'h009), 32'd0, 32'd0, 5'd0, 32'd3, 32'h09);
        cfg("vill", enc_vsetvl(5'd7, 5'd6, 5'd2), 32'd50, 32'd5, 5'd7, 32'd0, VILL_VT);
        issue(enc_arith(6'b000000, 3'b000, 5'd1, 5'd2, 5'd3), 0, 0, 1'b1);
        drain();

        cfg("restore", enc_vsetvli(5'd5, 5'd6, 11'h010), 32'd100, 32'd0, 5'd5, 32'd16, 32'h10);
        issue(enc_arith(6'b111111, 3'b000, 5'd4, 5'd5, 5'd6), 0, 0, 1'b1);
        issue(enc_arith(6'b100101, 3'b010, 5'd7, 5'd8, 5'd9), 0, 0, 1'b0);
        issue(enc_arith(6'b000000, 3'b001, 5'd10, 5'd11, 5'd12), 0, 0, 1'b1);
        issue(32'h0000_0033, 0, 0, 1'b0);
        issue(enc_arith(6'b000011, 3'b011, 5'd13, 5'd14, 5'd15), 0, 0, 1'b0);
        drain();

        uop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(enc_arith(6'b000000, 3'b000, 5'(i), 5'(i + 8), 5'(i + 16)), 0, 0, 1'b0);
        end
        chk("full_ready", inst_ready, 0);
        vec_inst   = enc_arith(6'b000000, 3'b000, 5'd4, 5'd12, 5'd20);
        inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_hold", inst_ready, 0);
        end
        uop_ready = 1'b1;
        issue(enc_arith(6'b000000, 3'b000, 5'd4, 5'd12, 5'd20), 0, 0, 1'b0);
        drain();

        uop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(enc_arith(6'b000000, 3'b000, 5'(i + 20), 5'(i + 1), 5'(i + 2)), 0, 0, 1'b0);
        end
        uop_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(enc_arith(6'b001001, 3'b000, 5'(i + 24), 5'(i + 3), 5'(31 - i)), 0, 0, 1'b0);
        end
        drain();

        uop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(enc_arith(6'b000000, 3'b000, 5'(i + 1), 5'd0, 5'd0), 0, 0, 1'b0);
        end
        vec_inst   = enc_arith(6'b000000, 3'b000, 5'd9, 5'd9, 5'd9);
        inst_valid = 1'b1;
        reset      = 1'b1;
        sb.delete();
        step();
        reset      = 1'b0;
        inst_valid = 1'b0;
        chk("flush_uop_valid", uop_valid, 0);
        chk("flush_inst_ready", inst_ready, 1);
        chk("flush_csr_vl", csr_vl, 0);
        chk("flush_csr_vtype", csr_vtype, VILL_VT);
        chk("flush_wb_valid", rd_wb_valid, 0);
        exp_vl    = '0;
        exp_vtype = VILL_VT;
        step();
        chk("flush_stay_empty", uop_valid, 0);

        uop_ready = 1'b1;
        issue(enc_vle32(5'd4, 5'd10), 32'h1000, 0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
